// File: rtl/json_motor_tx.sv
// json_motor_tx: formats signed wheel speeds as {"T":t,"L":±d.ff,"R":±d.ff}\n and streams it byte-wise
// Ports: clk; rst (async, active-high); spd_l/spd_r signed speeds in units of 1/10^FRAC_DIGITS;
//   req send request; tx_data/tx_valid/tx_ready byte handshake; busy frame in flight;
//   frame_done pulse on the last byte handshake.
// Optional build macro JSON_MOTOR_TX_CHK_EN appends ,"K":HH (hex mod-256 sum of preceding bytes) before '}'.
module json_motor_tx #(
    parameter int SPD_W            = 8,
    parameter int FRAC_DIGITS      = 2,
    parameter int TYPE_CODE        = 1,
    parameter int HEARTBEAT_CYCLES = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SPD_W-1:0] spd_l,
    input  logic [SPD_W-1:0] spd_r,
    input  logic             req,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done
);
    localparam int SCALE = FRAC_DIGITS == 1 ? 10 : FRAC_DIGITS == 2 ? 100 : 1000;
    localparam int MW    = SPD_W + 1 > 11 ? SPD_W + 1 : 11;
    localparam int DW    = 4 * (FRAC_DIGITS + 1);
    localparam int HW    = HEARTBEAT_CYCLES > 1 ? $clog2(HEARTBEAT_CYCLES) : 1;
`ifdef JSON_MOTOR_TX_CHK_EN
    localparam int CHK = 7;
    localparam logic [39:0] KSEP = ",\"K\":";
`else
    localparam int CHK = 0;
`endif
    localparam logic [87:0] HDR  = {"{\"T\":", 8'(48 + TYPE_CODE), ",\"L\":"};
    localparam logic [39:0] RSEP = ",\"R\":";
    localparam logic [15:0] TAIL = "}\n";

    typedef enum logic [1:0] {IDLE, LATCH, CONV, SEND} state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d, force_q, force_d, wh_q, wh_d;
    logic [1:0]       pl_q, pl_d, neg_q, neg_d;
    logic [HW-1:0]    hb_q, hb_d;
    logic [SPD_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic [MW-1:0]    rem_q, rem_d, mag_r_q, mag_r_d, pw;
    logic [DW-1:0]    dig_l_q, dig_l_d, dig_r_q, dig_r_d;
    logic [5:0]       idx_q, idx_d;
    logic [7:0]       byte_c;
    logic             chg, hb_exp, hs, last_b;
    int               p, s2, s3, s4;
`ifdef JSON_MOTOR_TX_CHK_EN
    logic [7:0]       sum_q, sum_d;
`endif

    // |v| computed one bit wider so the most-negative input cannot overflow, then clamped to 1.0
    function automatic logic [MW-1:0] mag(input logic [SPD_W-1:0] v);
        logic [MW-1:0] e, a;
        e = {{(MW - SPD_W){v[SPD_W-1]}}, v};
        a = v[SPD_W-1] ? -e : e;
        return a > MW'(SCALE) ? MW'(SCALE) : a;
    endfunction

    function automatic logic [MW-1:0] pw10(input logic [1:0] n);
        return n == 2'd0 ? MW'(1) : n == 2'd1 ? MW'(10) : n == 2'd2 ? MW'(100) : MW'(1000);
    endfunction

    // q is the offset within a number field: [-] int '.' frac...; digit 0 of d is the integer digit
    function automatic logic [7:0] num_chr(input int q, input logic m, input logic [DW-1:0] d);
        int k;
        k = q - int'(m);
        return (m && q == 0) ? 8'h2D : k == 1 ? 8'h2E : 8'h30 + {4'h0, d[4 * (k <= 0 ? 0 : k - 1) +: 4]};
    endfunction

`ifdef JSON_MOTOR_TX_CHK_EN
    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    assign pw         = pw10(2'(FRAC_DIGITS) - pl_q);
    assign chg        = spd_l != last_l_q || spd_r != last_r_q;
    assign hb_exp     = HEARTBEAT_CYCLES != 0 && state_q == IDLE && hb_q == HW'(HEARTBEAT_CYCLES - 1);
    assign tx_valid   = state_q == SEND;
    assign tx_data    = tx_valid ? byte_c : 8'h00;
    assign busy       = state_q != IDLE;
    assign hs         = tx_valid && tx_ready;
    assign last_b     = p == s4 + CHK + 1;
    assign frame_done = hs && last_b;

    // Field boundaries shift by one for each emitted minus sign
    always_comb begin
        p  = int'(idx_q);
        s2 = 13 + FRAC_DIGITS + int'(neg_q[0]);
        s3 = s2 + 5;
        s4 = s3 + 2 + FRAC_DIGITS + int'(neg_q[1]);
        byte_c = p < 11 ? HDR[8 * (10 - p) +: 8]
               : p < s2 ? num_chr(p - 11, neg_q[0], dig_l_q)
               : p < s3 ? RSEP[8 * (4 - p + s2) +: 8]
               : p < s4 ? num_chr(p - s3, neg_q[1], dig_r_q)
`ifdef JSON_MOTOR_TX_CHK_EN
               : p < s4 + 5 ? KSEP[8 * (4 - p + s4) +: 8]
               : p == s4 + 5 ? hex(sum_q[7:4])
               : p == s4 + 6 ? hex(sum_q[3:0])
`endif
               : TAIL[8 * (1 - p + s4 + CHK) +: 8];
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        force_d  = force_q;
        hb_d     = hb_q;
        last_l_d = last_l_q;
        last_r_d = last_r_q;
        neg_d    = neg_q;
        rem_d    = rem_q;
        mag_r_d  = mag_r_q;
        wh_d     = wh_q;
        pl_d     = pl_q;
        dig_l_d  = dig_l_q;
        dig_r_d  = dig_r_q;
        idx_d    = idx_q;
`ifdef JSON_MOTOR_TX_CHK_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: begin
                hb_d = HEARTBEAT_CYCLES == 0 ? hb_q : hb_q + 1'b1;
                if (req || chg || hb_exp || force_q) begin
                    state_d = LATCH;
                    force_d = 1'b0;
                end
            end
            LATCH: begin
                // inputs equal the snapshot this cycle, so only req can be a new trigger
                pend_d   = pend_q | req;
                state_d  = CONV;
                last_l_d = spd_l;
                last_r_d = spd_r;
                neg_d    = {spd_r[SPD_W-1] && mag(spd_r) != '0, spd_l[SPD_W-1] && mag(spd_l) != '0};
                rem_d    = mag(spd_l);
                mag_r_d  = mag(spd_r);
                wh_d     = 1'b0;
                pl_d     = 2'd0;
                dig_l_d  = '0;
                dig_r_d  = '0;
                idx_d    = '0;
`ifdef JSON_MOTOR_TX_CHK_EN
                sum_d    = '0;
`endif
            end
            CONV: begin
                pend_d = pend_q | req | chg;
                if (rem_q >= pw) begin
                    rem_d = rem_q - pw;
                    if (wh_q) dig_r_d[4 * pl_q +: 4] = dig_r_q[4 * pl_q +: 4] + 4'd1;
                    else dig_l_d[4 * pl_q +: 4] = dig_l_q[4 * pl_q +: 4] + 4'd1;
                end else if (pl_q != 2'(FRAC_DIGITS)) begin
                    pl_d = pl_q + 2'd1;
                end else if (!wh_q) begin
                    wh_d  = 1'b1;
                    pl_d  = 2'd0;
                    rem_d = mag_r_q;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                pend_d = pend_q | req | chg;
                if (hs) begin
                    idx_d = idx_q + 6'd1;
`ifdef JSON_MOTOR_TX_CHK_EN
                    sum_d = p < s4 ? sum_q + byte_c : sum_q;
`endif
                    if (last_b) begin
                        hb_d    = '0;
                        state_d = pend_d ? LATCH : IDLE;
                        pend_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            force_q  <= 1'b1;
            hb_q     <= '0;
            last_l_q <= '0;
            last_r_q <= '0;
            neg_q    <= '0;
            rem_q    <= '0;
            mag_r_q  <= '0;
            wh_q     <= 1'b0;
            pl_q     <= '0;
            dig_l_q  <= '0;
            dig_r_q  <= '0;
            idx_q    <= '0;
`ifdef JSON_MOTOR_TX_CHK_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            force_q  <= force_d;
            hb_q     <= hb_d;
            last_l_q <= last_l_d;
            last_r_q <= last_r_d;
            neg_q    <= neg_d;
            rem_q    <= rem_d;
            mag_r_q  <= mag_r_d;
            wh_q     <= wh_d;
            pl_q     <= pl_d;
            dig_l_q  <= dig_l_d;
            dig_r_q  <= dig_r_d;
            idx_q    <= idx_d;
`ifdef JSON_MOTOR_TX_CHK_EN
            sum_q    <= sum_d;
`endif
        end
    end
endmodule
